// File: rtl/bidir_pkg.sv
// Shared types for the half-duplex bus controller: direction FSM states and default width.
package bidir_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } state_t;

endpackage

// File: rtl/bidir_sync_fifo.sv
// Single-clock FIFO, synchronous active-high reset; an extra pointer bit separates full from empty.
// Combinational read of the head word; a push and a pop may happen in the same cycle.
module bidir_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex controller in front of a tristate buffer: queues outbound words, inserts dead
// turnaround cycles on every direction change, captures inbound words. Optional BIDIR_PARITY_EN.
module bidir_bus_ctrl
  import bidir_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TURN_CYC   = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              peer_req,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_stb,
  input  logic [DATA_W-1:0] bus_din,
  input  logic              bus_stb_in
`ifdef BIDIR_PARITY_EN
  ,
  output logic              bus_par_out,
  input  logic              bus_par_in,
  output logic              rx_perr
`endif
);

  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_t            state_q, state_d;
  logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              bus_oe_q, bus_stb_q;
  logic [DATA_W-1:0] bus_dout_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              capture;

  assign tx_ready  = !rst && !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign capture   = (state_q == RX) && bus_stb_in;

  bidir_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Words are popped on the edge that enters each TX bus cycle, so the bus registers always
  // show the word belonging to the current state.
  always_comb begin
    state_d     = state_q;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      RX: begin
        if (!fifo_empty && !peer_req && !bus_stb_in) begin
          state_d    = TURN_TX;
          turn_cnt_d = '0;
        end
      end
      TURN_TX: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d     = TX;
          turn_cnt_d  = '0;
          fifo_pop    = 1'b1;
          burst_cnt_d = BW'(1);
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      TX: begin
        if (fifo_empty || (peer_req && burst_cnt_q == BURST_MAX)) begin
          state_d    = TURN_RX;
          turn_cnt_d = '0;
        end else begin
          fifo_pop = 1'b1;
          if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      TURN_RX: begin
        burst_cnt_d = '0;
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = RX;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      default: state_d = RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
      bus_oe_q    <= 1'b0;
      bus_stb_q   <= 1'b0;
      bus_dout_q  <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      bus_oe_q    <= (state_d == TX);
      bus_stb_q   <= fifo_pop;
      if (fifo_pop) bus_dout_q <= fifo_dout;
      rx_valid_q  <= capture;
      if (capture) rx_data_q <= bus_din;
    end
  end

  assign bus_oe   = bus_oe_q;
  assign bus_stb  = bus_stb_q;
  assign bus_dout = bus_dout_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

`ifdef BIDIR_PARITY_EN
  logic bus_par_q, rx_perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_par_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      if (fifo_pop) bus_par_q <= ^fifo_dout;
      rx_perr_q <= capture && ((^bus_din) != bus_par_in);
    end
  end

  assign bus_par_out = bus_par_q;
  assign rx_perr     = rx_perr_q;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl with outbound/inbound scoreboards; define BIDIR_PARITY_EN
// to cover the parity ports as well.
module tb_bidir_bus_ctrl;

  localparam int TURN_CYC  = 2;
  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       peer_req = 1'b0;
  logic       bus_oe;
  logic [7:0] bus_dout;
  logic       bus_stb;
  logic [7:0] bus_din = '0;
  logic       bus_stb_in = 1'b0;
`ifdef BIDIR_PARITY_EN
  logic       bus_par_out;
  logic       bus_par_in = 1'b0;
  logic       rx_perr;
  logic       perrq[$];
`endif

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int stb_count = 0;
  logic oe_log [11];
  logic stb_log[11];

  always #5 clk = ~clk;

  bidir_bus_ctrl #(
    .DATA_W(8), .FIFO_DEPTH(4), .TURN_CYC(TURN_CYC), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .peer_req   (peer_req),
    .bus_oe     (bus_oe),
    .bus_dout   (bus_dout),
    .bus_stb    (bus_stb),
    .bus_din    (bus_din),
    .bus_stb_in (bus_stb_in)
`ifdef BIDIR_PARITY_EN
    ,
    .bus_par_out(bus_par_out),
    .bus_par_in (bus_par_in),
    .rx_perr    (rx_perr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until accepted; expected bus word goes to the scoreboard.
  task automatic drive_push(input logic [7:0] d);
    bit acc = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        acc = 1;
        txq.push_back(d);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("push_timeout", 32'(tx_ready), 32'd1);
  endtask

  task automatic wait_stb(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = bus_stb;
    end
    if (!seen) check("stb_timeout", 32'(bus_stb), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_oe_low(input int bound);
    bit low = 0;
    for (int i = 0; i < bound && !low; i++) begin
      @(negedge clk);
      low = !bus_oe;
    end
    if (!low) check("oe_low_timeout", 32'(bus_oe), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && txq.size() != 0; i++) cyc(1);
    if (txq.size() != 0) check("drain_timeout", 32'(txq.size()), 32'd0);
    cyc(TURN_CYC + 2);
    @(negedge clk);
    check("idle_oe", 32'(bus_oe), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0] w;
    if (!rst) begin
      if (bus_stb) begin
        stb_count++;
        check("stb_oe", 32'(bus_oe), 32'd1);
        if (txq.size() == 0) check("stb_spurious", 32'(bus_stb), 32'd0);
        else begin
          w = txq.pop_front();
          check("tx_word", 32'(bus_dout), 32'(w));
`ifdef BIDIR_PARITY_EN
          check("par_out", 32'(bus_par_out), 32'(^w));
`endif
        end
      end
      if (rx_valid) begin
        if (rxq.size() == 0) check("rx_spurious", 32'(rx_valid), 32'd0);
        else begin
          w = rxq.pop_front();
          check("rx_word", 32'(rx_data), 32'(w));
`ifdef BIDIR_PARITY_EN
          if (perrq.size() != 0) check("rx_perr", 32'(rx_perr), 32'(perrq.pop_front()));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_oe",       32'(bus_oe),   32'd0);
    check("rst_stb",      32'(bus_stb),  32'd0);
    check("rst_dout",     32'(bus_dout), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_tx_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;

    // Three words: decision cycle, TURN_CYC dead cycles, three strobes, TURN_CYC dead, RX
    fork
      begin
        drive_push(8'hA1);
        drive_push(8'hA2);
        drive_push(8'hA3);
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 11; i++) begin
          @(negedge clk);
          oe_log[i]  = bus_oe;
          stb_log[i] = bus_stb;
        end
      end
    join
    for (int i = 0; i < 11; i++) begin
      logic e;
      e = (i >= 2 + TURN_CYC) && (i < 5 + TURN_CYC);
      check($sformatf("t2_oe[%0d]", i),  32'(oe_log[i]),  32'(e));
      check($sformatf("t2_stb[%0d]", i), 32'(stb_log[i]), 32'(e));
    end
    @(posedge clk);
    #1;
    check("t2_drained", 32'(txq.size()), 32'd0);

    // Inbound strobe in RX
    bus_stb_in = 1'b1;
    bus_din    = 8'h5C;
    rxq.push_back(8'h5C);
`ifdef BIDIR_PARITY_EN
    bus_par_in = ^bus_din;
    perrq.push_back(1'b0);
`endif
    cyc(1);
    bus_stb_in = 1'b0;
    @(negedge clk);
    check("rx_pulse_hi", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rx_pulse_lo", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;

    // Full FIFO holds off the fifth word until the first pop
    peer_req = 1'b1;
    for (int i = 0; i < 4; i++) drive_push(8'hB0 + 8'(i));
    tx_data = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_tx_ready", 32'(tx_ready), 32'd0);
      check("full_oe",       32'(bus_oe),   32'd0);
      @(posedge clk);
      #1;
    end
    peer_req = 1'b0;
    drive_push(8'hB4);
    tx_valid = 1'b0;
    wait_drain(100);

    // 12-word stream with peer_req raised once TX starts: yield after MAX_BURST
    stb_count = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) drive_push(8'hC0 + 8'(i));
        tx_valid = 1'b0;
      end
      begin
        wait_stb(50);
        peer_req = 1'b1;
        wait_oe_low(50);
        check("burst_len", 32'(stb_count), 32'(MAX_BURST));
        cyc(6);
        check("burst_hold", 32'(stb_count), 32'(MAX_BURST));
        peer_req = 1'b0;
      end
    join
    wait_drain(100);
    check("burst_total", 32'(stb_count), 32'd12);

    // Peer strobe while we drive is dropped
    drive_push(8'hE0);
    drive_push(8'hE1);
    drive_push(8'hE2);
    tx_valid = 1'b0;
    wait_stb(50);
    bus_stb_in = 1'b1;
    bus_din    = 8'hEE;
    cyc(1);
    bus_stb_in = 1'b0;
    @(negedge clk);
    check("tx_stb_in_ignored", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_drain(100);

`ifdef BIDIR_PARITY_EN
    for (int k = 0; k < 2; k++) begin
      logic p;
      p = (k == 0);
      bus_din    = 8'h03;
      bus_par_in = p;
      bus_stb_in = 1'b1;
      rxq.push_back(8'h03);
      perrq.push_back((^bus_din) != p);
      cyc(1);
      bus_stb_in = 1'b0;
      @(negedge clk);
      check($sformatf("perr_direct[%0d]", k), 32'(rx_perr), 32'(p));
      @(posedge clk);
      #1;
    end
`endif

    // Reset in the middle of a TX burst
    for (int i = 0; i < 4; i++) drive_push(8'hD0 + 8'(i));
    tx_valid = 1'b0;
    wait_stb(50);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_oe",       32'(bus_oe),   32'd0);
    check("midrst_stb",      32'(bus_stb),  32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd0);
    txq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rel_ready", 32'(tx_ready), 32'd1);
    check("midrst_rel_oe",    32'(bus_oe),   32'd0);
    cyc(10);
    @(negedge clk);
    check("midrst_flushed_oe", 32'(bus_oe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
